// File: rtl/imm_decode_ctrl_pkg.sv
// Shared definitions for the immediate-decode controller: opcode constants,
// immediate-format encoding, occupancy states and the stored decoded entry.
package imm_decode_ctrl_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IR_W    = 25;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned SEL_W   = 3;

  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  typedef enum logic [SEL_W-1:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_sel_e;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'b00,
    OCC_PARTIAL = 2'b01,
    OCC_FULL    = 2'b10
  } occ_state_e;

  typedef struct packed {
    logic [IR_W-1:0]    ir;
    logic [INSTR_W-1:0] pc;
    imm_sel_e           imm_sel;
    logic               uses_imm;
    logic               illegal;
  } dec_entry_t;

endpackage

// File: rtl/imm_decode_ctrl_imm_sel_dec.sv
// Combinational opcode decoder: maps a 7-bit opcode to the immediate format,
// whether the instruction consumes an immediate, and whether it is illegal.
//   opcode      in  7  instruction bits [6:0]
//   imm_sel_c   out 3  immediate format (I/S/B/U/J)
//   uses_imm_c  out 1  instruction consumes the immediate
//   illegal_c   out 1  opcode not recognised
module imm_sel_dec
  import imm_decode_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic [SEL_W-1:0] imm_sel_c,
  output logic             uses_imm_c,
  output logic             illegal_c
);

  // Unknown opcodes fall through to the defaults: I-format, no imm, illegal.
  always_comb begin
    imm_sel_c  = IMM_I;
    uses_imm_c = 1'b0;
    illegal_c  = 1'b1;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        imm_sel_c  = IMM_I;
        uses_imm_c = 1'b1;
        illegal_c  = 1'b0;
      end
      OPC_STORE: begin
        imm_sel_c  = IMM_S;
        uses_imm_c = 1'b1;
        illegal_c  = 1'b0;
      end
      OPC_BRANCH: begin
        imm_sel_c  = IMM_B;
        uses_imm_c = 1'b1;
        illegal_c  = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_sel_c  = IMM_U;
        uses_imm_c = 1'b1;
        illegal_c  = 1'b0;
      end
      OPC_JAL: begin
        imm_sel_c  = IMM_J;
        uses_imm_c = 1'b1;
        illegal_c  = 1'b0;
      end
      OPC_OP: begin
        illegal_c  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_decode_ctrl.sv
// Instruction buffer with decode-at-write: accepts fetched instructions,
// decodes the immediate format and stores {IR, PC, format, flags} in a
// DEPTH-entry FIFO presented to the execute stage / immediate generator.
//   clk, rst_n        clock, async active-low reset
//   in_valid/ready    fetch handshake; in_ready is registered not-full
//   in_instr, in_pc   raw instruction word and address
//   flush             synchronous discard of all buffered entries
//   out_valid/ready   execute handshake; out_valid is not-empty
//   out_ir            INSTR[31:7] of head entry
//   out_imm_sel       immediate format of head entry
//   out_pc            PC of head entry
//   out_uses_imm      head consumes an immediate
//   out_illegal       head opcode unrecognised (0 when out_valid low)
//   illegal_cnt       saturating count of accepted illegal instructions
module imm_decode_ctrl
  import imm_decode_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [31:0]        in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [24:0]        out_ir,
  output logic [2:0]         out_imm_sel,
  output logic [31:0]        out_pc,
  output logic               out_uses_imm,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   illegal_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  occ_state_e       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             push_c;
  logic             pop_c;
  logic [SEL_W-1:0] dec_sel_c;
  logic             dec_uses_imm_c;
  logic             dec_illegal_c;
  dec_entry_t       wr_entry_c;
  dec_entry_t       head_c;
  dec_entry_t       mem [DEPTH];

  imm_sel_dec u_imm_sel_dec (
    .opcode     (in_instr[OPC_W-1:0]),
    .imm_sel_c  (dec_sel_c),
    .uses_imm_c (dec_uses_imm_c),
    .illegal_c  (dec_illegal_c)
  );

  // A transfer during flush is discarded, so it never counts as a push.
  assign push_c = in_valid & in_ready_q & ~flush;
  assign pop_c  = out_valid_q & out_ready;

  assign wr_entry_c = '{ir:       in_instr[31:7],
                        pc:       in_pc,
                        imm_sel:  imm_sel_e'(dec_sel_c),
                        uses_imm: dec_uses_imm_c,
                        illegal:  dec_illegal_c};

  // Next-state, pointer, occupancy and illegal-counter logic.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;

    if (push_c) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      OCC_EMPTY: begin
        if (push_c) state_d = OCC_PARTIAL;
      end
      OCC_PARTIAL: begin
        if (push_c && !pop_c && (count_q == OCC_W'(DEPTH - 1))) begin
          state_d = OCC_FULL;
        end else if (pop_c && !push_c && (count_q == OCC_W'(1))) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop_c) state_d = OCC_PARTIAL;
      end
      default: state_d = OCC_EMPTY;
    endcase

    if (flush) begin
      state_d  = OCC_EMPTY;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    if (push_c && dec_illegal_c && !(&illegal_cnt_q)) begin
      illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
    end
  end

  // Control state; handshake flags are registered from the next state so
  // in_ready has no combinational path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= OCC_EMPTY;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
      in_ready_q    <= (state_d != OCC_FULL);
      out_valid_q   <= (state_d != OCC_EMPTY);
    end
  end

  // Entry storage is data-only and needs no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= wr_entry_c;
    end
  end

  assign head_c       = mem[rd_ptr_q];
  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_ir       = head_c.ir;
  assign out_imm_sel  = head_c.imm_sel;
  assign out_pc       = head_c.pc;
  assign out_uses_imm = head_c.uses_imm;
  assign out_illegal  = out_valid_q & head_c.illegal;
  assign illegal_cnt  = illegal_cnt_q;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Self-checking bench for imm_decode_ctrl: directed stimulus with
// hand-computed expectations queued at handshake time and compared by a
// separate output monitor.
module tb_imm_decode_ctrl;

  typedef struct {
    logic [24:0] ir;
    logic [2:0]  sel;
    logic [31:0] pc;
    logic        uses;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_ir;
  logic [2:0]  out_imm_sel;
  logic [31:0] out_pc;
  logic        out_uses_imm;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  logic        d2_in_ready;
  logic        d2_out_valid;
  logic [24:0] d2_out_ir;
  logic [2:0]  d2_out_imm_sel;
  logic [31:0] d2_out_pc;
  logic        d2_out_uses_imm;
  logic        d2_out_illegal;
  logic [1:0]  d2_illegal_cnt;

  int   checks = 0;
  int   errors = 0;
  int   n_pops = 0;
  exp_t sb[$];
  exp_t exp_cur;

  // Vectors for the simultaneous push/pop run.
  logic [31:0] v_instr [6] = '{32'h00000037, 32'h00000017, 32'h002081B3,
                               32'h00002003, 32'h00000067, 32'h00000073};
  logic [24:0] v_ir    [6] = '{25'h0, 25'h0, 25'h04103, 25'h00040, 25'h0, 25'h0};
  logic [2:0]  v_sel   [6] = '{3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
  logic        v_uses  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  imm_decode_ctrl #(.DEPTH(2), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ir       (out_ir),
    .out_imm_sel  (out_imm_sel),
    .out_pc       (out_pc),
    .out_uses_imm (out_uses_imm),
    .out_illegal  (out_illegal),
    .illegal_cnt  (illegal_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  imm_decode_ctrl #(.DEPTH(2), .CNT_W(2)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (d2_in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .flush        (flush),
    .out_valid    (d2_out_valid),
    .out_ready    (out_ready),
    .out_ir       (d2_out_ir),
    .out_imm_sel  (d2_out_imm_sel),
    .out_pc       (d2_out_pc),
    .out_uses_imm (d2_out_uses_imm),
    .out_illegal  (d2_out_illegal),
    .illegal_cnt  (d2_illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one instruction until it is accepted; called at posedge+1.
  task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [2:0] sel, input logic uses, input logic ill);
    int n;
    bit rdy;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    exp_cur  = '{ir: instr[31:7], sel: sel, pc: pc, uses: uses, ill: ill};
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL push_timeout: pc 0x%0h not accepted after %0d cycles", pc, n);
    end
  endtask

  // Output monitor: compare popped entries, then record new accepted inputs.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        n_pops++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: pc 0x%0h ir 0x%0h with empty scoreboard", out_pc, out_ir);
        end else begin
          e = sb.pop_front();
          if (out_ir !== e.ir || out_imm_sel !== e.sel || out_pc !== e.pc ||
              out_uses_imm !== e.uses || out_illegal !== e.ill) begin
            errors++;
            $display("FAIL entry: got ir=0x%0h sel=%0d pc=0x%0h uses=%0b ill=%0b expected ir=0x%0h sel=%0d pc=0x%0h uses=%0b ill=%0b",
                     out_ir, out_imm_sel, out_pc, out_uses_imm, out_illegal,
                     e.ir, e.sel, e.pc, e.uses, e.ill);
          end
        end
      end
      if (!out_valid) begin
        checks++;
        if (out_illegal !== 1'b0) begin
          errors++;
          $display("FAIL illegal_when_idle: got %0b expected 0", out_illegal);
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_valid && in_ready) begin
        sb.push_back(exp_cur);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    exp_cur   = '{ir: '0, sel: '0, pc: '0, uses: 1'b0, ill: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("in_ready_after_edge", 32'(in_ready), 32'd1);

    // Single I-type with out_ready high; visible the cycle after accept
    out_ready = 1'b1;
    push(32'h00500093, 32'h100, 3'd0, 1'b1, 1'b0);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    chk("latency_out_ir", 32'(out_ir), 32'h0A001);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_drained", 32'(out_valid), 32'd0);

    // Fill with S and B, third (J) waits for the first pop
    out_ready = 1'b0;
    push(32'h0020A223, 32'h200, 3'd1, 1'b1, 1'b0);
    push(32'h00208463, 32'h204, 3'd2, 1'b1, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    fork
      push(32'h008000EF, 32'h208, 3'd4, 1'b1, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("full_hold_in_ready", 32'(in_ready), 32'd0);
        chk("full_hold_head_sel", 32'(out_imm_sel), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_pop", 32'(in_ready), 32'd1);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("t2_drained", 32'(out_valid), 32'd0);

    // Illegal opcodes and counter saturation
    for (int i = 0; i < 3; i++) begin
      push(32'h00000000, 32'h300 + 32'(4 * i), 3'd0, 1'b0, 1'b1);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("illegal_cnt_3", 32'(illegal_cnt), 32'd3);
    chk("illegal_cnt_w2_3", 32'(d2_illegal_cnt), 32'd3);
    push(32'h00000000, 32'h30C, 3'd0, 1'b0, 1'b1);
    push(32'h00000000, 32'h310, 3'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("illegal_cnt_5", 32'(illegal_cnt), 32'd5);
    chk("illegal_cnt_w2_sat", 32'(d2_illegal_cnt), 32'd3);

    // Count 1, simultaneous push and pop for 6 cycles
    out_ready = 1'b0;
    push(32'h00100113, 32'h400, 3'd0, 1'b1, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_cur = '{ir: v_ir[i], sel: v_sel[i], pc: 32'h404 + 32'(4 * i), uses: v_uses[i], ill: 1'b0};
      push(v_instr[i], 32'h404 + 32'(4 * i), v_sel[i], v_uses[i], 1'b0);
      chk("pp_out_valid", 32'(out_valid), 32'd1);
      chk("pp_in_ready", 32'(in_ready), 32'd1);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("t4_drained", 32'(out_valid), 32'd0);

    // Flush with two entries buffered and an illegal instruction offered
    out_ready = 1'b0;
    push(32'h00500093, 32'h500, 3'd0, 1'b1, 1'b0);
    push(32'h0020A223, 32'h504, 3'd1, 1'b1, 1'b0);
    chk("pre_flush_full", 32'(in_ready), 32'd0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h0;
    in_pc    = 32'h508;
    exp_cur  = '{ir: '0, sel: 3'd0, pc: 32'h508, uses: 1'b0, ill: 1'b1};
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_illegal_cnt", 32'(illegal_cnt), 32'd5);
    chk("flush_in_ready", 32'(in_ready), 32'd1);

    // Flush with one entry: pop completes, illegal transfer discarded
    push(32'h00100113, 32'h600, 3'd0, 1'b1, 1'b0);
    out_ready = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h0;
    in_pc     = 32'h604;
    exp_cur   = '{ir: '0, sel: 3'd0, pc: 32'h604, uses: 1'b0, ill: 1'b1};
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_pop_out_valid", 32'(out_valid), 32'd0);
    chk("flush_pop_illegal_cnt", 32'(illegal_cnt), 32'd5);
    chk("flush_pop_illegal_cnt_w2", 32'(d2_illegal_cnt), 32'd3);

    // Reset mid-drain with two entries
    out_ready = 1'b0;
    push(32'h00000037, 32'h700, 3'd3, 1'b1, 1'b0);
    push(32'h0000006F, 32'h704, 3'd4, 1'b1, 1'b0);
    out_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    push(32'h00C00513, 32'h800, 3'd0, 1'b1, 1'b0);
    chk("post_rst_ir", 32'(out_ir), 32'h1800A);
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("total_pops", 32'(n_pops), 32'd18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
